ddr2_mem_dq_responder: RTL and testbench

Memory-side counterpart of the controller's DQ/DQS/DM data-path IOBs. It lets the controller data path be verified against a synthesizable DDR2 device data-path model. The block accepts read/write burst commands and holds write data in a small internal array. It captures masked write bursts after write latency (CAS_LAT-1) and returns read bursts after CAS_LAT, with DQS preamble and output-enable timing. Data is in rise/fall split form, one clock, so the block pairs directly with the controller's rise/fall data buses in the system bench.

---
 rtl/ddr2_mem_dq_responder.sv | 125 ++++++++++++
 tb/tb_ddr2_mem_dq_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr2_mem_dq_responder.sv
// DDR2 device-side DQ/DQS/DM data-path model with a small burst array.
// Rise/fall split data, write latency CAS_LAT-1, read latency CAS_LAT.
module ddr2_mem_dq_responder #(
  parameter int DATA_WIDTH = 16,
  parameter int MASK_WIDTH = 2,
  parameter int ADDR_WIDTH = 4,
  parameter int CAS_LAT    = 3,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset0,
  input  logic                  cmd_valid,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] wr_dq_rise,
  input  logic [DATA_WIDTH-1:0] wr_dq_fall,
  input  logic [MASK_WIDTH-1:0] wr_dm_rise,
  input  logic [MASK_WIDTH-1:0] wr_dm_fall,
  output logic [DATA_WIDTH-1:0] rd_dq_rise,
  output logic [DATA_WIDTH-1:0] rd_dq_fall,
  output logic                  dq_oe,
  output logic                  dqs_oe,
  output logic                  protocol_err
);

  localparam int HALF  = BURST_LEN / 2;
  localparam int LB    = $clog2(HALF);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RD_BURST,
    WR_BURST
  } state_t;

  state_t                state;
  state_t                state_nx;
  logic [3:0]            phase;
  logic [LB-1:0]         beat;
  logic [ADDR_WIDTH-1:0] base;
  logic                  is_wr;
  logic                  accept;
  logic [3:0]            lat_acc;
  logic [3:0]            lat_cur;
  logic [ADDR_WIDTH-1:0] addr_cur;

  logic [DATA_WIDTH-1:0] mem_rise [DEPTH];
  logic [DATA_WIDTH-1:0] mem_fall [DEPTH];

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign lat_acc   = cmd_write ? 4'(CAS_LAT - 1) : 4'(CAS_LAT);
  assign lat_cur   = is_wr ? 4'(CAS_LAT - 1) : 4'(CAS_LAT);

  // Beat address wraps inside the burst-aligned block.
  assign addr_cur = {base[ADDR_WIDTH-1:LB], base[LB-1:0] + beat};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (accept)
          state_nx = (lat_acc == 4'd1) ? WR_BURST : WAIT;
      WAIT:
        if (phase == lat_cur - 4'd1)
          state_nx = is_wr ? WR_BURST : RD_BURST;
      RD_BURST, WR_BURST:
        if (beat == LB'(HALF - 1))
          state_nx = IDLE;
      default:
        state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset0) begin
    if (reset0) begin
      state        <= IDLE;
      phase        <= '0;
      beat         <= '0;
      base         <= '0;
      is_wr        <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        base  <= cmd_addr;
        is_wr <= cmd_write;
        phase <= 4'd1;
      end else if (state != IDLE) begin
        phase <= phase + 4'd1;
      end else begin
        phase <= '0;
      end
      if (state == RD_BURST || state == WR_BURST)
        beat <= beat + LB'(1);
      else
        beat <= '0;
      if (cmd_valid && !cmd_ready)
        protocol_err <= 1'b1;
    end
  end

  // Array holds contents across reset.
  always_ff @(posedge clk) begin
    if (state == WR_BURST) begin
      for (int b = 0; b < MASK_WIDTH; b++) begin
        if (!wr_dm_rise[b])
          mem_rise[addr_cur][b*8 +: 8] <= wr_dq_rise[b*8 +: 8];
        if (!wr_dm_fall[b])
          mem_fall[addr_cur][b*8 +: 8] <= wr_dq_fall[b*8 +: 8];
      end
    end
  end

  assign dq_oe  = (state == RD_BURST);
  assign dqs_oe = !is_wr &&
                  ((state == RD_BURST) ||
                   (state == WAIT && phase == 4'(CAS_LAT - 1)));

  assign rd_dq_rise = dq_oe ? mem_rise[addr_cur] : '0;
  assign rd_dq_fall = dq_oe ? mem_fall[addr_cur] : '0;

endmodule

// File: tb/tb_ddr2_mem_dq_responder.sv
// Bench for ddr2_mem_dq_responder: cycle-indexed expectation model
// plus literal checks of the directed scenarios.
module tb_ddr2_mem_dq_responder;

  localparam int DW  = 16;
  localparam int MW  = 2;
  localparam int AW  = 4;
  localparam int CAS = 3;
  localparam int BL  = 4;
  localparam int H   = BL / 2;

  logic          clk = 1'b0;
  logic          reset0 = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic          cmd_ready;
  logic [DW-1:0] wr_dq_rise = '0;
  logic [DW-1:0] wr_dq_fall = '0;
  logic [MW-1:0] wr_dm_rise = '0;
  logic [MW-1:0] wr_dm_fall = '0;
  logic [DW-1:0] rd_dq_rise;
  logic [DW-1:0] rd_dq_fall;
  logic          dq_oe;
  logic          dqs_oe;
  logic          protocol_err;

  ddr2_mem_dq_responder #(
    .DATA_WIDTH(DW), .MASK_WIDTH(MW), .ADDR_WIDTH(AW),
    .CAS_LAT(CAS), .BURST_LEN(BL)
  ) dut (
    .clk(clk), .reset0(reset0),
    .cmd_valid(cmd_valid), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_ready(cmd_ready),
    .wr_dq_rise(wr_dq_rise), .wr_dq_fall(wr_dq_fall),
    .wr_dm_rise(wr_dm_rise), .wr_dm_fall(wr_dm_fall),
    .rd_dq_rise(rd_dq_rise), .rd_dq_fall(rd_dq_fall),
    .dq_oe(dq_oe), .dqs_oe(dqs_oe),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;
  bit chk = 1'b0;
  int err_from = 1 << 30;

  // Device array model and per-cycle expected outputs.
  logic [DW-1:0] mr [16];
  logic [DW-1:0] mf [16];
  bit            mv [16];
  bit            e_busy [int];
  bit            e_dqs [int];
  bit            e_dq [int];
  bit            e_known [int];
  logic [DW-1:0] e_r [int];
  logic [DW-1:0] e_f [int];

  logic [DW-1:0] br [H];
  logic [DW-1:0] bf [H];
  logic [MW-1:0] bdr [H];
  logic [MW-1:0] bdf [H];

  task automatic check(string nm, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  function automatic int baddr(int a, int i);
    return (a / H) * H + ((a % H) + i) % H;
  endfunction

  always @(negedge clk) begin
    if (chk) begin
      check("cmd_ready", 32'(cmd_ready), 32'(!e_busy.exists(cyc)));
      check("dqs_oe", 32'(dqs_oe), 32'(e_dqs.exists(cyc)));
      check("dq_oe", 32'(dq_oe), 32'(e_dq.exists(cyc)));
      check("protocol_err", 32'(protocol_err), 32'(cyc >= err_from));
      if (!e_dq.exists(cyc)) begin
        check("rd_rise_idle", 32'(rd_dq_rise), 32'h0);
        check("rd_fall_idle", 32'(rd_dq_fall), 32'h0);
      end else if (e_known.exists(cyc)) begin
        check("rd_rise", 32'(rd_dq_rise), 32'(e_r[cyc]));
        check("rd_fall", 32'(rd_dq_fall), 32'(e_f[cyc]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at(int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  task automatic set_beat(int i, logic [DW-1:0] r, logic [DW-1:0] f,
                          logic [MW-1:0] dr, logic [MW-1:0] df);
    br[i] = r; bf[i] = f; bdr[i] = dr; bdf[i] = df;
  endtask

  task automatic drive_dead();
    wr_dq_rise = 16'hDEAD; wr_dq_fall = 16'hBEEF;
    wr_dm_rise = '0; wr_dm_fall = '0;
  endtask

  task automatic do_write(int a);
    int t;
    int i;
    int ea;
    t = cyc;
    for (int c = t + 1; c <= t + CAS + H - 2; c++) e_busy[c] = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = AW'(a);
    step();
    cmd_valid = 1'b0;
    while (cyc <= t + CAS + H - 2) begin
      if (cyc >= t + CAS - 1) begin
        i = cyc - (t + CAS - 1);
        ea = baddr(a, i);
        wr_dq_rise = br[i]; wr_dq_fall = bf[i];
        wr_dm_rise = bdr[i]; wr_dm_fall = bdf[i];
        for (int b = 0; b < MW; b++) begin
          if (!bdr[i][b]) mr[ea][b*8 +: 8] = br[i][b*8 +: 8];
          if (!bdf[i][b]) mf[ea][b*8 +: 8] = bf[i][b*8 +: 8];
        end
        mv[ea] = 1'b1;
      end else begin
        drive_dead();
      end
      step();
    end
    drive_dead();
  endtask

  task automatic issue_read(int a, output int t);
    int ea;
    t = cyc;
    for (int c = t + 1; c <= t + CAS + H - 1; c++) e_busy[c] = 1'b1;
    for (int c = t + CAS - 1; c <= t + CAS + H - 1; c++) e_dqs[c] = 1'b1;
    for (int i = 0; i < H; i++) begin
      ea = baddr(a, i);
      e_dq[t + CAS + i] = 1'b1;
      if (mv[ea]) begin
        e_known[t + CAS + i] = 1'b1;
        e_r[t + CAS + i] = mr[ea];
        e_f[t + CAS + i] = mf[ea];
      end
    end
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = AW'(a);
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    int t;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    drive_dead();

    // Reset state
    step(); step();
    @(negedge clk);
    check("rst_ready", 32'(cmd_ready), 32'h1);
    check("rst_dq_oe", 32'(dq_oe), 32'h0);
    check("rst_dqs_oe", 32'(dqs_oe), 32'h0);
    check("rst_err", 32'(protocol_err), 32'h0);
    check("rst_rise", 32'(rd_dq_rise), 32'h0);
    step();
    reset0 = 1'b0;
    step();
    chk = 1'b1;

    // Plain write then read
    set_beat(0, 16'h1111, 16'h2222, 2'b00, 2'b00);
    set_beat(1, 16'h3333, 16'h4444, 2'b00, 2'b00);
    do_write(4);
    step();
    issue_read(4, t);
    at(t + 2);
    check("t2_preamble_dqs", 32'(dqs_oe), 32'h1);
    check("t2_preamble_dq", 32'(dq_oe), 32'h0);
    at(t + 3);
    check("t2_b0_rise", 32'(rd_dq_rise), 32'h1111);
    check("t2_b0_fall", 32'(rd_dq_fall), 32'h2222);
    at(t + 4);
    check("t2_b1_rise", 32'(rd_dq_rise), 32'h3333);
    check("t2_b1_fall", 32'(rd_dq_fall), 32'h4444);
    at(t + 5);
    check("t2_ready_back", 32'(cmd_ready), 32'h1);
    step();

    // Masked write
    set_beat(0, 16'hAAAA, 16'hBBBB, 2'b01, 2'b10);
    set_beat(1, 16'hFFFF, 16'hFFFF, 2'b11, 2'b11);
    do_write(4);
    issue_read(4, t);
    at(t + 3);
    check("t3_b0_rise", 32'(rd_dq_rise), 32'hAA11);
    check("t3_b0_fall", 32'(rd_dq_fall), 32'h22BB);
    at(t + 4);
    check("t3_b1_rise", 32'(rd_dq_rise), 32'h3333);
    check("t3_b1_fall", 32'(rd_dq_fall), 32'h4444);
    step();

    // Address wrap within burst block
    set_beat(0, 16'h5050, 16'h6060, 2'b00, 2'b00);
    set_beat(1, 16'h7070, 16'h8080, 2'b00, 2'b00);
    do_write(4);
    issue_read(5, t);
    at(t + 3);
    check("t4_b0_rise", 32'(rd_dq_rise), 32'h7070);
    check("t4_b0_fall", 32'(rd_dq_fall), 32'h8080);
    at(t + 4);
    check("t4_b1_rise", 32'(rd_dq_rise), 32'h5050);
    check("t4_b1_fall", 32'(rd_dq_fall), 32'h6060);
    step();

    // Command while busy
    issue_read(4, t);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'd0;
    err_from = t + 2;
    step();
    cmd_valid = 1'b0;
    at(t + 3);
    check("t5_b0_rise", 32'(rd_dq_rise), 32'h5050);
    at(t + 6);
    check("t5_err_sticky", 32'(protocol_err), 32'h1);
    check("t5_ready", 32'(cmd_ready), 32'h1);
    step(); step();

    // Reset during a read burst
    issue_read(5, t);
    while (cyc < t + 3) step();
    chk = 1'b0;
    reset0 = 1'b1;
    #1;
    check("t6_rst_dq_oe", 32'(dq_oe), 32'h0);
    check("t6_rst_dqs_oe", 32'(dqs_oe), 32'h0);
    check("t6_rst_rise", 32'(rd_dq_rise), 32'h0);
    check("t6_rst_fall", 32'(rd_dq_fall), 32'h0);
    check("t6_rst_err", 32'(protocol_err), 32'h0);
    check("t6_rst_ready", 32'(cmd_ready), 32'h1);
    e_busy.delete(); e_dqs.delete(); e_dq.delete();
    e_known.delete(); e_r.delete(); e_f.delete();
    err_from = 1 << 30;
    step(); step();
    reset0 = 1'b0;
    step();
    chk = 1'b1;
    issue_read(5, t);
    at(t + 3);
    check("t6_b0_rise", 32'(rd_dq_rise), 32'h7070);
    check("t6_b0_fall", 32'(rd_dq_fall), 32'h8080);
    at(t + 4);
    check("t6_b1_rise", 32'(rd_dq_rise), 32'h5050);
    check("t6_b1_fall", 32'(rd_dq_fall), 32'h6060);
    step(); step(); step();
    chk = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
